prod_serializer_128to32: RTL
============================

# prod_serializer_128to32

Output stage placed directly downstream of the 4-input 32-bit pipelined multiplier. It tracks operand-issue validity through a delay line matched to the multiplier latency, and captures each 128-bit product into a small FIFO. It drains each product as four 32-bit words over a valid/ready stream. The multiplier cannot stall, so this block absorbs backpressure and flags any product it must drop.

## Interface
- MUL_LATENCY, 3: clock edges from operands presented at the multiplier inputs to the product on `g_outM`; valid delay-line length.
- DEPTH, 4: FIFO entries of 128 bits; power of two, ≥2.
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset; one clock, one reset, both fixed.
- issue_valid  in  1  high in the cycle valid operands are driven onto the multiplier inputs.
- prod_in  in  128  connected to multiplier `g_outM`.
- out_data  out  32  current word of the head product.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts the word when `out_valid && out_ready`.
- out_last  out  1  high with word 3 (most significant) of a product.
- ovf  out  1  sticky: a product was dropped.
- ovf_clr  in  1  clears ovf.
- fifo_level  out  $clog2(DEPTH)+1  stored products, including the one being drained.

## Operation
- Delay line `vsr[MUL_LATENCY-1:0]`: `vsr[0]<=issue_valid`, `vsr[i]<=vsr[i-1]`. `vsr[MUL_LATENCY-1]` high means `prod_in` holds the matching product in that cycle.
- Write: at the edge where `vsr[MUL_LATENCY-1]=1`, push `prod_in` unless the FIFO is full after that cycle's pop.
- Full with no pop in that cycle: drop the product, set ovf, leave contents unchanged.
- Full with a pop completing in the same cycle: the write is accepted and the level stays DEPTH.
- Serializer: 2-bit word index `widx`.
  - `out_data = head[32*widx +: 32]`, least significant word first.
  - `out_valid = (level!=0)`; `out_last = out_valid && widx==3`.
  - On handshake, `widx++`. When the handshake has `widx==3`, pop the head and set `widx` to 0.
- out_data, out_last and widx hold while `out_valid && !out_ready`.
- ovf: set on drop, cleared by ovf_clr. If a drop and ovf_clr occur in the same cycle, set wins.
- Pointers wrap modulo DEPTH. Level uses the extra bit so full and empty are distinct.
- Reset values: vsr=0, pointers=0, level=0, widx=0, ovf=0. Outputs are out_valid=0, out_last=0, out_data=0, fifo_level=0.
  - FIFO storage is not reset; out_data is forced to 0 when the FIFO is empty.
- Reset mid-drain discards all stored products and products still in flight in vsr.

## Timing
- issue_valid in cycle 0 (MUL_LATENCY=3): product written at the edge ending cycle 3.
- Word 0 is presented in cycle 4, so issue to first word is 4 cycles.
- Write to out_valid: 1 cycle; no combinational path from prod_in to outputs.
- Sustained drain is 1 word/cycle with out_ready=1, so a product takes 4 cycles.
- Back-to-back products are accepted at most one every 4 cycles without net FIFO growth.
- out_ready→out_valid has no combinational dependency; out_data changes only at an edge.

## Configuration
- `PROD_SER_OVF_CNT_EN` defined:
  - Adds port `ovf_cnt out 8`, a saturating count of dropped products, saturating at 255.
  - Cleared by reset and by ovf_clr. If a drop coincides with ovf_clr, the count becomes 1.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- Package `prod_ser_pkg`: `WORD_W=32`, `PROD_W=128`, `WORDS_PER_PROD=4`, typedef `prod_t` (logic [127:0]), typedef `word_t` (logic [31:0]).
- One sub-module, `prod_fifo`: synchronous FIFO parameterised by DEPTH and width.
  - Provides push, pop, full, empty and level.
  - Supports push and pop in the same cycle when full.
- The top level holds the delay line, serializer index and ovf logic.

## Test plan
- Single product: out_ready=1, issue_valid pulse in cycle 0, prod_in=128'h0000000000000000_DEADBEEF_12345678 in cycle 3.
  - Required: words 0x12345678, 0xDEADBEEF, 0x0, 0x0 in cycles 4–7; out_last in cycle 7.
- Backpressure: out_ready toggles 1,0,0,1,…
  - Required: no word is skipped or duplicated, and out_data is stable while stalled.
- Overflow: out_ready=0, issue 5 products with DEPTH=4.
  - Required: fifo_level=4; ovf=1 after the fifth write attempt; ovf_cnt=1 when `PROD_SER_OVF_CNT_EN` is defined.
  - Drain yields products 1–4 only.
- Full plus simultaneous pop: DEPTH products stored, and a write arrives on the edge that word 3 of the head is accepted.
  - Required: write accepted, level stays 4, ovf stays 0.
- Reset mid-drain: rst_n low for 1 cycle after word 1 of a product, with 2 products pending in vsr.
  - Required: all outputs 0 next cycle; no words emerge afterwards without new issue_valid.
- ovf_clr coinciding with a drop: ovf stays 1; ovf_cnt=1 when enabled.

Source files
------------

// File: rtl/prod_serializer_128to32_pkg.sv
// Shared types and widths for the 128-to-32 product serializer.
package prod_ser_pkg;

    localparam int WORD_W         = 32;
    localparam int PROD_W         = 128;
    localparam int WORDS_PER_PROD = 4;
    localparam int WIDX_W         = $clog2(WORDS_PER_PROD);

    typedef logic [PROD_W-1:0] prod_t;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [WIDX_W-1:0] widx_t;

    function automatic word_t word_of(input prod_t p, input widx_t idx);
        return p[WORD_W*idx +: WORD_W];
    endfunction

endpackage

// File: rtl/prod_serializer_128to32_if.sv
// 32-bit valid/ready word stream leaving the serializer.
interface prod_serializer_128to32_if;
    import prod_ser_pkg::*;

    word_t out_data;
    logic  out_valid;
    logic  out_ready;
    logic  out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/prod_serializer_128to32_fifo.sv
// Synchronous FIFO; a push is accepted while full when a pop completes in the same cycle.
module prod_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 128
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign level   = level_q;
    assign dout    = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; level gates every read, so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/prod_serializer_128to32.sv
// Captures multiplier products via a latency-matched valid delay line and drains them as 32-bit words.
// Optional PROD_SER_OVF_CNT_EN adds a saturating dropped-product counter port ovf_cnt.
module prod_serializer_128to32
    import prod_ser_pkg::*;
#(
    parameter int MUL_LATENCY = 3,
    parameter int DEPTH       = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          issue_valid,
    input  prod_t                         prod_in,
    prod_serializer_128to32_if.master     strm,
    output logic                          ovf,
`ifdef PROD_SER_OVF_CNT_EN
    output logic [7:0]                    ovf_cnt,
`endif
    input  logic                          ovf_clr,
    output logic [$clog2(DEPTH):0]        fifo_level
);

    logic [MUL_LATENCY-1:0] vsr;
    logic                   arrive;
    widx_t                  widx;
    prod_t                  head;
    logic                   full;
    logic                   empty;
    logic                   hs;
    logic                   pop;
    logic                   drop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsr <= '0;
        end else begin
            vsr[0] <= issue_valid;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                vsr[i] <= vsr[i-1];
            end
        end
    end

    // The tail of the delay line marks the cycle in which prod_in carries a real product.
    assign arrive = vsr[MUL_LATENCY-1];
    assign hs     = strm.out_valid && strm.out_ready;
    assign pop    = hs && (widx == widx_t'(WORDS_PER_PROD-1));
    assign drop   = arrive && full && !pop;

    prod_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PROD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (arrive),
        .pop   (pop),
        .din   (prod_in),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            widx <= '0;
        end else if (pop) begin
            widx <= '0;
        end else if (hs) begin
            widx <= widx + 1'b1;
        end
    end

    // Outputs derive only from registered state, so out_ready never feeds back combinationally.
    assign strm.out_valid = !empty;
    assign strm.out_data  = empty ? '0 : word_of(head, widx);
    assign strm.out_last  = !empty && (widx == widx_t'(WORDS_PER_PROD-1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

`ifdef PROD_SER_OVF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (drop) begin
            if (ovf_clr)              ovf_cnt <= 8'd1;
            else if (ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
        end else if (ovf_clr) begin
            ovf_cnt <= '0;
        end
    end
`endif

endmodule
